time_entry_ctrl: RTL and testbench

Keypad-entry controller sitting directly downstream of the keypad decoder. Counts digits announced by `shift_pulse`, captures the four-nibble BCD entry, validates it as HH:MM (24 h), and on a set-time or set-alarm button issues a one-cycle load strobe carrying the time to the clock or alarm register. Also owns the keypad clear: it pulses `reset_shift` after every commit, cancel, timeout or error.

---
 rtl/alarm_pkg.sv | 40 ++++
 rtl/edge_sync.sv | 29 ++
 rtl/time_entry_ctrl.sv | 133 +++++++++++++
 tb/tb_time_entry_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm-clock keypad entry path.
// Holds the entry FSM states, BCD limit constants and the HH:MM validity check.
package alarm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        COMMIT,
        ERROR
    } entry_state_t;

    localparam logic [3:0] BLANK_DIGIT    = 4'hA;
    localparam logic [3:0] H_TENS_MAX     = 4'd2;
    localparam logic [3:0] H_ONES_MAX_20S = 4'd3;
    localparam logic [3:0] M_TENS_MAX     = 4'd5;
    localparam logic [3:0] DIGIT_MAX      = 4'd9;

    // 24 h HH:MM check on four BCD nibbles, [15:12] = hours tens.
    function automatic logic hhmm_valid(input logic [15:0] v);
        logic [3:0] h_tens;
        logic [3:0] h_ones;
        logic [3:0] m_tens;
        logic [3:0] m_ones;
        logic       no_blank;
        h_tens   = v[15:12];
        h_ones   = v[11:8];
        m_tens   = v[7:4];
        m_ones   = v[3:0];
        no_blank = (h_tens != BLANK_DIGIT) && (h_ones != BLANK_DIGIT) &&
                   (m_tens != BLANK_DIGIT) && (m_ones != BLANK_DIGIT);
        hhmm_valid = no_blank &&
                     (h_tens <= H_TENS_MAX) &&
                     (h_ones <= DIGIT_MAX) &&
                     !((h_tens == H_TENS_MAX) && (h_ones > H_ONES_MAX_20S)) &&
                     (m_tens <= M_TENS_MAX) &&
                     (m_ones <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Output is a one-cycle pulse three clocks after the asynchronous input rises.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync_p0 <= async_in;
            sync_p1 <= sync_p0;
            // edge register stage
            prev_p2 <= sync_p1;
            pulse   <= sync_p1 & ~prev_p2;
        end
    end

endmodule

// File: rtl/time_entry_ctrl.sv
// Keypad time-entry controller: counts digits, validates HH:MM and issues
// one-cycle load strobes to the clock or alarm register.
module time_entry_ctrl
    import alarm_pkg::*;
#(
    parameter int TIMEOUT_S  = 10,
    parameter int ERR_HOLD_S = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] keypad_values,
    input  logic        shift_pulse,
    input  logic        set_time_btn,
    input  logic        set_alarm_btn,
    input  logic        cancel_btn,
    input  logic        tick_1hz,
    output logic        reset_shift,
    output logic        load_time,
    output logic        load_alarm,
    output logic [15:0] time_bcd,
    output logic        entry_active,
    output logic        entry_error,
    output logic [2:0]  digit_count
);

    localparam int TW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;
    localparam int EW = (ERR_HOLD_S > 1) ? $clog2(ERR_HOLD_S) : 1;

    logic shift_ev, time_ev, alarm_ev, cancel_ev;

    edge_sync u_sync_shift  (.clk(clk), .rst_n(rst_n), .async_in(shift_pulse),   .pulse(shift_ev));
    edge_sync u_sync_time   (.clk(clk), .rst_n(rst_n), .async_in(set_time_btn),  .pulse(time_ev));
    edge_sync u_sync_alarm  (.clk(clk), .rst_n(rst_n), .async_in(set_alarm_btn), .pulse(alarm_ev));
    edge_sync u_sync_cancel (.clk(clk), .rst_n(rst_n), .async_in(cancel_btn),    .pulse(cancel_ev));

    entry_state_t  state, state_nx;
    logic [2:0]    count, count_nx, cnt_inc;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic [EW-1:0] ecnt, ecnt_nx;
    logic          sel_alarm, sel_alarm_nx;
    logic          rs_nx, lt_nx, la_nx;
    logic [15:0]   entry_reg;

    always_comb begin
        state_nx     = state;
        count_nx     = count;
        cnt_inc      = count;
        tcnt_nx      = tcnt;
        ecnt_nx      = ecnt;
        sel_alarm_nx = sel_alarm;
        case (state)
            IDLE: begin
                if (shift_ev) begin
                    state_nx = COLLECT;
                    count_nx = 3'd1;
                    tcnt_nx  = '0;
                end
            end
            COLLECT: begin
                // A set in the same cycle as a digit is judged on the new count.
                if (shift_ev && (count != 3'd4))
                    cnt_inc = count + 3'd1;
                count_nx = cnt_inc;
                if (shift_ev)
                    tcnt_nx = '0;
                else if (tick_1hz)
                    tcnt_nx = tcnt + TW'(1);
                if (cancel_ev) begin
                    state_nx = IDLE;
                end else if (time_ev || alarm_ev) begin
                    sel_alarm_nx = !time_ev;
                    state_nx     = (cnt_inc == 3'd4) ? CHECK : ERROR;
                end else if (!shift_ev && tick_1hz && (tcnt == TW'(TIMEOUT_S - 1))) begin
                    state_nx = IDLE;
                end
            end
            CHECK:  state_nx = hhmm_valid(entry_reg) ? COMMIT : ERROR;
            COMMIT: state_nx = IDLE;
            ERROR: begin
                if (tick_1hz) begin
                    if (ecnt == EW'(ERR_HOLD_S - 1))
                        state_nx = IDLE;
                    else
                        ecnt_nx = ecnt + EW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        if ((state_nx == ERROR) && (state != ERROR))
            ecnt_nx = '0;
        if (state_nx == IDLE)
            count_nx = 3'd0;
        // Every way out of an entry clears the keypad exactly once.
        rs_nx = ((state == COLLECT) && (state_nx == IDLE)) ||
                ((state_nx == ERROR) && (state != ERROR)) ||
                (state_nx == COMMIT);
        lt_nx = (state_nx == COMMIT) && !sel_alarm;
        la_nx = (state_nx == COMMIT) && sel_alarm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= 3'd0;
            tcnt        <= '0;
            ecnt        <= '0;
            sel_alarm   <= 1'b0;
            reset_shift <= 1'b0;
            load_time   <= 1'b0;
            load_alarm  <= 1'b0;
            entry_reg   <= {4{BLANK_DIGIT}};
            time_bcd    <= 16'h0000;
        end else begin
            state       <= state_nx;
            count       <= count_nx;
            tcnt        <= tcnt_nx;
            ecnt        <= ecnt_nx;
            sel_alarm   <= sel_alarm_nx;
            reset_shift <= rs_nx;
            load_time   <= lt_nx;
            load_alarm  <= la_nx;
            if (shift_ev)
                entry_reg <= keypad_values;
            if (state_nx == COMMIT)
                time_bcd <= entry_reg;
        end
    end

    assign entry_active = (state == COLLECT);
    assign entry_error  = (state == ERROR);
    assign digit_count  = count;

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Self-checking bench for time_entry_ctrl: directed entries plus randomized
// digit/button scenarios predicted by a transaction-level reference model.
module tb_time_entry_ctrl;

    localparam int TIMEOUT_S  = 10;
    localparam int ERR_HOLD_S = 2;

    localparam int ACT_TIME    = 0;
    localparam int ACT_ALARM   = 1;
    localparam int ACT_BOTH    = 2;
    localparam int ACT_CANCEL  = 3;
    localparam int ACT_ALL     = 4;
    localparam int ACT_TIMEOUT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keypad_values = 16'hAAAA;
    logic        shift_pulse = 1'b0;
    logic        set_time_btn = 1'b0;
    logic        set_alarm_btn = 1'b0;
    logic        cancel_btn = 1'b0;
    logic        tick_1hz = 1'b0;
    logic        reset_shift, load_time, load_alarm, entry_active, entry_error;
    logic [15:0] time_bcd;
    logic [2:0]  digit_count;

    time_entry_ctrl #(.TIMEOUT_S(TIMEOUT_S), .ERR_HOLD_S(ERR_HOLD_S)) dut (
        .clk(clk), .rst_n(rst_n), .keypad_values(keypad_values),
        .shift_pulse(shift_pulse), .set_time_btn(set_time_btn),
        .set_alarm_btn(set_alarm_btn), .cancel_btn(cancel_btn),
        .tick_1hz(tick_1hz), .reset_shift(reset_shift), .load_time(load_time),
        .load_alarm(load_alarm), .time_bcd(time_bcd), .entry_active(entry_active),
        .entry_error(entry_error), .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_bcd = 16'h0000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: counts strobes and flags width / coincidence violations.
    int n_rs = 0, n_lt = 0, n_la = 0, n_bad = 0;
    logic [15:0] load_bcd = 16'h0000;
    logic rs_prev = 1'b0, lt_prev = 1'b0, la_prev = 1'b0;
    always @(negedge clk) begin
        if (reset_shift) n_rs++;
        if (load_time) n_lt++;
        if (load_alarm) n_la++;
        if ((reset_shift && rs_prev) || (load_time && lt_prev) || (load_alarm && la_prev) ||
            (load_time && load_alarm) || ((load_time || load_alarm) && !reset_shift))
            n_bad++;
        if (load_time || load_alarm) load_bcd = time_bcd;
        rs_prev = reset_shift;
        lt_prev = load_time;
        la_prev = load_alarm;
    end

    function automatic bit ref_valid(input logic [15:0] v);
        int d[4];
        for (int i = 0; i < 4; i++) begin
            d[i] = int'(v[4*i +: 4]);
            if (d[i] > 9) return 1'b0;
        end
        return ((d[3] * 10 + d[2]) < 24) && ((d[1] * 10 + d[0]) < 60);
    endfunction

    function automatic logic [19:0] pack4(input int a, input int b, input int c, input int d);
        return {4'hA, 4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mask = {cancel, set_alarm, set_time, shift}
    task automatic press(input logic [3:0] m);
        {cancel_btn, set_alarm_btn, set_time_btn, shift_pulse} = m;
        wait_cyc(2);
        {cancel_btn, set_alarm_btn, set_time_btn, shift_pulse} = 4'b0000;
        wait_cyc(6);
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        wait_cyc(1);
        tick_1hz = 1'b0;
        wait_cyc(2);
    endtask

    task automatic run_trial(input int n, input logic [19:0] digs, input int act);
        logic [15:0] kp;
        int rs0, lt0, la0, bad0;
        bit is_set, commit, is_err;
        kp   = 16'hAAAA;
        rs0  = n_rs;
        lt0  = n_lt;
        la0  = n_la;
        bad0 = n_bad;
        for (int k = 0; k < n; k++) begin
            kp = {kp[11:0], digs[4*k +: 4]};
            keypad_values = kp;
            wait_cyc(1);
            press(4'b0001);
            check_eq("digit_count", 32'(digit_count), (k + 1 > 4) ? 4 : k + 1);
            check_eq("entry_active", 32'(entry_active), 1);
        end
        case (act)
            ACT_TIME:   press(4'b0010);
            ACT_ALARM:  press(4'b0100);
            ACT_BOTH:   press(4'b0110);
            ACT_CANCEL: press(4'b1000);
            ACT_ALL:    press(4'b1110);
            default: begin
                repeat (TIMEOUT_S - 1) tick();
                check_eq("pre_timeout_active", 32'(entry_active), 1);
                check_eq("pre_timeout_rs", n_rs - rs0, 0);
                tick();
            end
        endcase
        is_set = (act == ACT_TIME) || (act == ACT_ALARM) || (act == ACT_BOTH);
        commit = is_set && (n >= 4) && ref_valid(kp);
        is_err = is_set && !commit;
        if (commit) exp_bcd = kp;
        check_eq("entry_error", 32'(entry_error), 32'(is_err));
        if (is_err) begin
            repeat (ERR_HOLD_S - 1) tick();
            check_eq("err_hold", 32'(entry_error), 1);
            tick();
            check_eq("err_release", 32'(entry_error), 0);
        end
        check_eq("reset_shift_pulses", n_rs - rs0, 1);
        check_eq("load_time_pulses", n_lt - lt0, (commit && act != ACT_ALARM) ? 1 : 0);
        check_eq("load_alarm_pulses", n_la - la0, (commit && act == ACT_ALARM) ? 1 : 0);
        check_eq("strobe_shape", n_bad - bad0, 0);
        check_eq("time_bcd", 32'(time_bcd), 32'(exp_bcd));
        if (commit) check_eq("load_bcd", 32'(load_bcd), 32'(kp));
        check_eq("idle_count", 32'(digit_count), 0);
        check_eq("idle_active", 32'(entry_active), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_time_bcd"}, 32'(time_bcd), 0);
        check_eq({tag, "_count"}, 32'(digit_count), 0);
        check_eq({tag, "_flags"}, 32'({entry_active, entry_error, reset_shift, load_time, load_alarm}), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] digs;
        int n, act, hh, mm, rs0;
        wait_cyc(3);
        check_reset_values("reset");
        rst_n = 1'b1;
        wait_cyc(3);

        run_trial(4, pack4(1, 2, 3, 4), ACT_TIME);
        check_eq("commit_1234", 32'(time_bcd), 32'h1234);
        run_trial(4, pack4(2, 4, 0, 0), ACT_ALARM);
        run_trial(2, pack4(0, 7, 10, 10), ACT_TIME);
        check_eq("short_keeps_bcd", 32'(time_bcd), 32'h1234);
        run_trial(2, pack4(0, 9, 10, 10), ACT_TIMEOUT);
        run_trial(4, pack4(2, 3, 5, 9), ACT_ALL);
        run_trial(4, pack4(2, 3, 5, 9), ACT_ALARM);
        run_trial(4, pack4(0, 0, 0, 0), ACT_BOTH);

        for (int t = 0; t < 40; t++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 4;
            digs = '0;
            if ($urandom_range(0, 2) != 0) begin
                hh = $urandom_range(0, 23);
                mm = $urandom_range(0, 59);
                digs = {4'($urandom_range(0, 9)), pack4(hh / 10, hh % 10, mm / 10, mm % 10)};
            end else begin
                for (int k = 0; k < 5; k++) digs[4*k +: 4] = 4'($urandom_range(0, 10));
            end
            act = $urandom_range(0, 5);
            run_trial(n, digs, act);
        end

        // Reset dropped between the third and fourth digit.
        rs0 = n_rs;
        keypad_values = 16'hAAAA;
        for (int k = 1; k <= 3; k++) begin
            keypad_values = {keypad_values[11:0], 4'(k)};
            wait_cyc(1);
            press(4'b0001);
        end
        check_eq("pre_reset_count", 32'(digit_count), 3);
        rst_n = 1'b0;
        wait_cyc(3);
        check_reset_values("midreset");
        check_eq("midreset_no_rs", n_rs - rs0, 0);
        rst_n = 1'b1;
        exp_bcd = 16'h0000;
        wait_cyc(3);
        run_trial(4, pack4(1, 9, 4, 5), ACT_TIME);
        check_eq("post_reset_commit", 32'(time_bcd), 32'h1945);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
